// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the team FIFO: pulls BURST_LEN words and frames them on a valid/ready stream.
// Optional partial-burst flush on idle timeout is enabled by defining FLUSH_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int FIFO_WIDTH     = 14,
  parameter int FIFO_DEPTH     = 64,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CW            = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CW-1:0]         fifo_count,
  input  logic                  fifo_empty,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  busy,
  output logic [15:0]           burst_done_cnt
);

  localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         remaining, cur_len, word_idx, load_len;
  logic                  inflight;
  logic [1:0]            q_occ;
  logic [FIFO_WIDTH-1:0] q_data0, q_data1;
  logic                  q_sof0, q_sof1, q_eof0, q_eof1;
  logic                  in_sof, in_eof, pop, start_burst;
  logic                  flush_hit;

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] idle_timer;
  logic          partial;

  assign partial   = (state == IDLE) && (fifo_count != '0) && (fifo_count < BLEN);
  assign flush_hit = partial && (idle_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_timer <= '0;
    end else if (partial && !flush_hit) begin
      idle_timer <= idle_timer + TW'(1);
    end else begin
      idle_timer <= '0;
    end
  end
`else
  assign flush_hit = 1'b0;
`endif

  // The word returning from the FIFO falls through to the head when the queue is
  // empty, which gives rd_en-to-m_valid of one cycle and full throughput.
  always_comb begin
    in_sof  = (word_idx == '0);
    in_eof  = (word_idx == cur_len - CW'(1));
    m_valid = (q_occ != 2'd0) || inflight;
    if (q_occ != 2'd0) begin
      m_data = q_data0;
      m_sof  = q_sof0;
      m_eof  = q_eof0;
    end else begin
      m_data = inflight ? rd_data : '0;
      m_sof  = inflight && in_sof;
      m_eof  = inflight && in_eof;
    end
    pop   = m_valid && m_ready;
    rd_en = (state == BURST) && (remaining != '0) && !fifo_empty &&
            ((q_occ + {1'b0, inflight}) < 2'd2);
    busy  = (state == BURST);
  end

  always_comb begin
    state_nxt   = state;
    load_len    = BLEN;
    start_burst = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count >= BLEN) begin
          start_burst = 1'b1;
          state_nxt   = BURST;
        end else if (flush_hit) begin
          start_burst = 1'b1;
          load_len    = fifo_count;
          state_nxt   = BURST;
        end
      end
      BURST: begin
        if (pop && m_eof) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      remaining      <= '0;
      cur_len        <= '0;
      word_idx       <= '0;
      inflight       <= 1'b0;
      q_occ          <= 2'd0;
      q_data0        <= '0;
      q_data1        <= '0;
      q_sof0         <= 1'b0;
      q_sof1         <= 1'b0;
      q_eof0         <= 1'b0;
      q_eof1         <= 1'b0;
      burst_done_cnt <= 16'h0000;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (start_burst) begin
        remaining <= load_len;
        cur_len   <= load_len;
        word_idx  <= '0;
      end else begin
        if (rd_en) begin
          remaining <= remaining - CW'(1);
        end
        if (inflight) begin
          word_idx <= word_idx + CW'(1);
        end
      end

      q_occ <= q_occ + {1'b0, inflight} - {1'b0, pop};
      // Two outstanding words at most, so a push never meets a full queue.
      if (q_occ == 2'd0) begin
        if (inflight && !pop) begin
          q_data0 <= rd_data;
          q_sof0  <= in_sof;
          q_eof0  <= in_eof;
        end
      end else if (q_occ == 2'd1) begin
        if (inflight && pop) begin
          q_data0 <= rd_data;
          q_sof0  <= in_sof;
          q_eof0  <= in_eof;
        end else if (inflight) begin
          q_data1 <= rd_data;
          q_sof1  <= in_sof;
          q_eof1  <= in_eof;
        end
      end else if (pop) begin
        q_data0 <= q_data1;
        q_sof0  <= q_sof1;
        q_eof0  <= q_eof1;
      end

      if (pop && m_eof && (burst_done_cnt != 16'hFFFF)) begin
        burst_done_cnt <= burst_done_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed self-checking bench for fifo_burst_reader with a behavioural FIFO model
// (registered read data, bulk writes so a whole block lands in one cycle).
module tb_fifo_burst_reader;

  localparam int W  = 14;
  localparam int D  = 64;
  localparam int BL = 16;
  localparam int TO = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n, fifo_rst_n;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, rd_en;
  logic [W-1:0]  rd_data, m_data;
  logic          m_valid, m_ready, m_sof, m_eof, busy;
  logic [15:0]   burst_done_cnt;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .FIFO_WIDTH    (W),
    .FIFO_DEPTH    (D),
    .BURST_LEN     (BL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_count    (fifo_count),
    .fifo_empty    (fifo_empty),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_sof         (m_sof),
    .m_eof         (m_eof),
    .busy          (busy),
    .burst_done_cnt(burst_done_cnt)
  );

  // FIFO model
  logic [W-1:0] mem [D];
  int           wp, rp, cnt;
  int           wrN;
  logic [W-1:0] wrBase;

  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      wp      <= 0;
      rp      <= 0;
      cnt     <= 0;
      rd_data <= '0;
    end else begin
      if (rd_en) begin
        rd_data <= mem[rp];
        rp      <= (rp + 1) % D;
      end
      for (int i = 0; i < wrN; i++) mem[(wp + i) % D] <= wrBase + W'(i);
      wp  <= (wp + wrN) % D;
      cnt <= cnt + wrN - (rd_en ? 1 : 0);
    end
  end

  assign fifo_count = CW'(cnt);
  assign fifo_empty = (cnt == 0);

  // Stream monitor, sampled on the falling edge
  logic [W-1:0] bData [$];
  logic         bSof [$];
  logic         bEof [$];
  int           bCyc [$];
  int           cyc = 0, rdPulses = 0, outst = 0, maxOut = 0, stallErr = 0, stallCnt = 0;
  logic         prevStall = 1'b0;
  logic [W-1:0] prevData = '0;

  always @(negedge clk) begin
    cyc++;
    if (rd_en === 1'b1) rdPulses++;
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      bData.push_back(m_data);
      bSof.push_back(m_sof);
      bEof.push_back(m_eof);
      bCyc.push_back(cyc);
    end
    if (prevStall && (m_valid !== 1'b1 || m_data !== prevData)) stallErr++;
    prevStall = (rst_n === 1'b1) && (m_valid === 1'b1) && (m_ready === 1'b0);
    if (prevStall) stallCnt++;
    prevData = m_data;
    if (rst_n !== 1'b1) begin
      outst = 0;
    end else begin
      outst += (rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (outst > maxOut) maxOut = outst;
    end
  end

  int           checks = 0, passes = 0;
  int           pendN = 0, readyMode = 0, phase = 0;
  logic [W-1:0] pendBase = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    wrN    = pendN;
    wrBase = pendBase;
    pendN  = 0;
    if (readyMode == 0) begin
      m_ready = 1'b1;
    end else begin
      m_ready = (phase % 3 == 0);
      phase++;
    end
  endtask

  task automatic writeWords(input logic [W-1:0] base, input int n);
    pendBase = base;
    pendN    = n;
    applyStimulus();
  endtask

  task automatic resetAll();
    applyStimulus();
    rst_n      = 1'b0;
    fifo_rst_n = 1'b0;
    applyStimulus();
    applyStimulus();
    rst_n      = 1'b1;
    fifo_rst_n = 1'b1;
  endtask

  task automatic checkBurst(input string tag, input int start, input int n, input logic [W-1:0] base);
    int sofs, eofs;
    if (bData.size() < start + n) begin
      checkOutput({tag, " short"}, bData.size(), start + n);
    end else begin
      sofs = 0;
      eofs = 0;
      for (int i = 0; i < n; i++) begin
        checkOutput({tag, " data"}, bData[start+i], base + W'(i));
        sofs += bSof[start+i] ? 1 : 0;
        eofs += bEof[start+i] ? 1 : 0;
      end
      checkOutput({tag, " sof first"}, bSof[start], 1);
      checkOutput({tag, " eof last"}, bEof[start+n-1], 1);
      checkOutput({tag, " sof count"}, sofs, 1);
      checkOutput({tag, " eof count"}, eofs, 1);
    end
  endtask

  int   b0, b1, rd0, firstHigh, lastHigh, lows;
  logic got5;
  logic busyHist [40];

  initial begin
    rst_n      = 1'b0;
    fifo_rst_n = 1'b0;
    m_ready    = 1'b1;
    wrN        = 0;
    wrBase     = '0;
    repeat (2) applyStimulus();
    fifo_rst_n = 1'b1;

    // Reset held with 20 words waiting
    writeWords(14'h101, 20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput("reset rd_en", rd_en, 0);
      checkOutput("reset m_valid", m_valid, 0);
      checkOutput("reset busy", busy, 0);
    end
    checkOutput("reset fifo_count", fifo_count, 20);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset m_sof", m_sof, 0);
    checkOutput("reset m_eof", m_eof, 0);
    checkOutput("reset done_cnt", burst_done_cnt, 0);
    applyStimulus();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release cycle1 rd_en", rd_en, 0);
    applyStimulus();
    @(negedge clk);
    checkOutput("release cycle2 rd_en", rd_en, 1);
    checkOutput("release cycle2 busy", busy, 1);
    repeat (30) applyStimulus();
    resetAll();

    // Single full burst, m_ready high
    b0  = bData.size();
    rd0 = rdPulses;
    writeWords(14'h001, 16);
    repeat (40) applyStimulus();
    @(negedge clk);
    checkOutput("t2 beats", bData.size() - b0, 16);
    checkBurst("t2", b0, 16, 14'h001);
    if (bData.size() >= b0 + 16) checkOutput("t2 consecutive", bCyc[b0+15] - bCyc[b0], 15);
    checkOutput("t2 done_cnt", burst_done_cnt, 1);
    checkOutput("t2 rd pulses", rdPulses - rd0, 16);
    checkOutput("t2 busy", busy, 0);

    // Burst with m_ready pattern 1,0,0
    readyMode = 1;
    phase     = 0;
    b0        = bData.size();
    writeWords(14'h201, 16);
    repeat (120) applyStimulus();
    readyMode = 0;
    @(negedge clk);
    checkOutput("t3 beats", bData.size() - b0, 16);
    checkBurst("t3", b0, 16, 14'h201);
    checkOutput("t3 max outstanding<=2", maxOut <= 2, 1);
    checkOutput("t3 stall stable", stallErr, 0);
    checkOutput("t3 stalls seen", stallCnt > 0, 1);
    checkOutput("t3 done_cnt", burst_done_cnt, 2);

    // Residual words below BURST_LEN
    b0  = bData.size();
    rd0 = rdPulses;
    writeWords(14'h301, 15);
`ifdef FLUSH_TIMEOUT_EN
    repeat (100) applyStimulus();
    @(negedge clk);
    checkOutput("t4 beats", bData.size() - b0, 15);
    checkBurst("t4", b0, 15, 14'h301);
    checkOutput("t4 done_cnt", burst_done_cnt, 3);
    checkOutput("t4 fifo_count", fifo_count, 0);
`else
    repeat (1000) applyStimulus();
    @(negedge clk);
    checkOutput("t4 rd pulses", rdPulses - rd0, 0);
    checkOutput("t4 beats", bData.size() - b0, 0);
    checkOutput("t4 busy", busy, 0);
    checkOutput("t4 fifo_count", fifo_count, 15);
`endif
    resetAll();

    // 40 words: two back-to-back bursts, 8 left behind
    b0        = bData.size();
    firstHigh = -1;
    lastHigh  = -1;
    writeWords(14'h401, 40);
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      @(negedge clk);
      busyHist[i] = busy;
      if (busy) begin
        if (firstHigh < 0) firstHigh = i;
        lastHigh = i;
      end
    end
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (firstHigh >= 0 && i > firstHigh && i < lastHigh && !busyHist[i]) lows++;
    end
    checkOutput("t5 beats", bData.size() - b0, 32);
    checkBurst("t5 first", b0, 16, 14'h401);
    checkBurst("t5 second", b0 + 16, 16, 14'h411);
    checkOutput("t5 done_cnt", burst_done_cnt, 2);
    checkOutput("t5 fifo_count", fifo_count, 8);
    checkOutput("t5 busy gap<=1", lows <= 1, 1);
    resetAll();

    // Reset after the 5th beat, then a clean burst
    b0   = bData.size();
    got5 = 1'b0;
    writeWords(14'h601, 16);
    for (int i = 0; i < 60 && !got5; i++) begin
      applyStimulus();
      @(negedge clk);
      if (bData.size() - b0 >= 5) got5 = 1'b1;
    end
    checkOutput("t6 reached 5th beat", got5, 1);
    applyStimulus();
    rst_n      = 1'b0;
    fifo_rst_n = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("t6 m_valid", m_valid, 0);
    checkOutput("t6 m_data", m_data, 0);
    checkOutput("t6 m_sof", m_sof, 0);
    checkOutput("t6 m_eof", m_eof, 0);
    checkOutput("t6 busy", busy, 0);
    checkOutput("t6 rd_en", rd_en, 0);
    checkOutput("t6 done_cnt", burst_done_cnt, 0);
    b1 = bData.size();
    applyStimulus();
    rst_n      = 1'b1;
    fifo_rst_n = 1'b1;
    writeWords(14'h701, 16);
    repeat (40) applyStimulus();
    @(negedge clk);
    checkOutput("t6 new beats", bData.size() - b1, 16);
    checkBurst("t6 new", b1, 16, 14'h701);
    checkOutput("t6 new done_cnt", burst_done_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
